// File: rtl/can_reg_access_ctrl_if.sv
// Bus-side handshake of the CAN register access stage: one-pulse select, R/W and
// write data in; registered read data and response pulses out.
interface can_reg_access_ctrl_if #(
  parameter int unsigned NUM_REGS = 31,
  parameter int unsigned DATA_W   = 8
);
  logic [NUM_REGS-1:0] rs_vector;
  logic                r_neg_w;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                wr_ack;
  logic                acc_err;

  modport master (
    output rs_vector, r_neg_w, wr_data,
    input  rd_data, rd_valid, wr_ack, acc_err
  );

  modport slave (
    input  rs_vector, r_neg_w, wr_data,
    output rd_data, rd_valid, wr_ack, acc_err
  );
endinterface

// File: rtl/can_reg_access_ctrl.sv
// CAN register bank access stage: protected writes, read-to-clear IR, registered responses.
// Optional CAN_REG_ACC_ERR_EN adds a saturating reject counter and a sticky reject flag.
module can_reg_access_ctrl #(
  parameter int unsigned         NUM_REGS      = 31,
  parameter int unsigned         DATA_W        = 8,
  parameter int unsigned         MODE_IDX      = 0,
  parameter int unsigned         IR_IDX        = 3,
  parameter logic [NUM_REGS-1:0] RO_MASK       = 31'h0000_000C,
  parameter logic [NUM_REGS-1:0] RST_ONLY_MASK = 31'h0000_01F0,
  parameter logic [DATA_W-1:0]   MODE_RST      = 8'h01
) (
  input  logic                       i_sys_clk,
  input  logic                       i_reset,
  can_reg_access_ctrl_if.slave       bus,
  input  logic [DATA_W-1:0]          i_status,
  input  logic [DATA_W-1:0]          i_irq_set,
  output logic [NUM_REGS*DATA_W-1:0] o_regs,
  output logic                       o_reset_mode
`ifdef CAN_REG_ACC_ERR_EN
  ,
  output logic [7:0]                 o_err_cnt,
  output logic                       o_err_sticky
`endif
);

  localparam int unsigned STATUS_IDX = 2;

  typedef enum logic [1:0] {IDLE, RD_RSP, WR_RSP, ERR_RSP} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   rd_mux;
  logic [DATA_W-1:0]   ir_clr;
  logic [DATA_W-1:0]   mode_wr_val;
  logic                any_sel, one_hot, hit_ro, hit_rst_only, mode_rst;
  logic                rd_ok, wr_ok, reject;

  always_comb begin
    any_sel      = |bus.rs_vector;
    one_hot      = any_sel && ((bus.rs_vector & (bus.rs_vector - NUM_REGS'(1))) == '0);
    hit_ro       = |(bus.rs_vector & RO_MASK);
    hit_rst_only = |(bus.rs_vector & RST_ONLY_MASK);
    mode_rst     = regs[MODE_IDX][0];
    rd_ok        = one_hot && bus.r_neg_w;
    wr_ok        = one_hot && !bus.r_neg_w &&
                   (bus.rs_vector[MODE_IDX] || (!hit_ro && !(hit_rst_only && !mode_rst)));
    reject       = any_sel && !rd_ok && !wr_ok;
    ir_clr       = (rd_ok && bus.rs_vector[IR_IDX]) ? '1 : '0;
    mode_wr_val  = bus.wr_data;
`ifdef CAN_REG_ACC_ERR_EN
    mode_wr_val[7] = 1'b0;
`endif
    // select is one-hot whenever this value is consumed, so OR-ing is a plain mux
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.rs_vector[i]) begin
        rd_mux = rd_mux | ((i == STATUS_IDX) ? i_status : regs[i]);
      end
    end
  end

  // IR is hardware-owned: set strobes win over read-to-clear in the same cycle
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == MODE_IDX) ? MODE_RST : '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (i == IR_IDX) begin
          regs[i] <= (regs[i] & ~ir_clr) | i_irq_set;
        end else if (wr_ok && bus.rs_vector[i]) begin
          regs[i] <= (i == MODE_IDX) ? mode_wr_val : bus.wr_data;
        end
      end
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_data_q <= '0;
    end else if (rd_ok) begin
      rd_data_q <= rd_mux;
    end
  end

`ifdef CAN_REG_ACC_ERR_EN
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      o_err_cnt    <= '0;
      o_err_sticky <= 1'b0;
    end else begin
      if (reject && (o_err_cnt != 8'hFF)) begin
        o_err_cnt <= o_err_cnt + 8'd1;
      end
      if (reject) begin
        o_err_sticky <= 1'b1;
      end else if (wr_ok && bus.rs_vector[MODE_IDX] && bus.wr_data[7]) begin
        o_err_sticky <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    if (!any_sel) begin
      state_nxt = IDLE;
    end else if (rd_ok) begin
      state_nxt = RD_RSP;
    end else if (wr_ok) begin
      state_nxt = WR_RSP;
    end else begin
      state_nxt = ERR_RSP;
    end
  end

  always_comb begin
    bus.rd_valid = (state == RD_RSP);
    bus.wr_ack   = (state == WR_RSP);
    bus.acc_err  = (state == ERR_RSP);
    bus.rd_data  = rd_data_q;
    o_reset_mode = regs[MODE_IDX][0];
    o_regs       = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      o_regs[i*DATA_W +: DATA_W] = regs[i];
    end
  end

endmodule

// File: tb/tb_can_reg_access_ctrl.sv
// Scoreboard bench for can_reg_access_ctrl: stimulus queues expected response pulses,
// a negedge monitor pops and compares kind, data and arrival cycle.
module tb_can_reg_access_ctrl;

  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [7:0]   status;
  logic [7:0]   irq;
  logic [247:0] regs_flat;
  logic         reset_mode;
`ifdef CAN_REG_ACC_ERR_EN
  logic [7:0]   err_cnt;
  logic         err_sticky;
`endif

  exp_t q[$];
  int   cyc;
  int   n_cmp;
  int   n_bad;

  can_reg_access_ctrl_if bus_if ();

  can_reg_access_ctrl dut (
    .i_sys_clk    (clk),
    .i_reset      (rst),
    .bus          (bus_if),
    .i_status     (status),
    .i_irq_set    (irq),
    .o_regs       (regs_flat),
    .o_reset_mode (reset_mode)
`ifdef CAN_REG_ACC_ERR_EN
    ,
    .o_err_cnt    (err_cnt),
    .o_err_sticky (err_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response pulse must match the head of the queue, in the right cycle
  always @(negedge clk) begin
    int   npulse;
    int   akind;
    exp_t e;
    if (!rst) begin
      npulse = int'(bus_if.rd_valid) + int'(bus_if.wr_ack) + int'(bus_if.acc_err);
      if (npulse != 0) begin
        n_cmp++;
        akind = bus_if.rd_valid ? K_RD : (bus_if.wr_ack ? K_WR : K_ERR);
        if (npulse > 1) begin
          n_bad++;
          $display("FAIL pulse_overlap: got %0d pulses in cycle %0d, required 1", npulse, cyc);
        end else if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: got kind %0d in cycle %0d, required none", akind, cyc);
        end else begin
          e = q.pop_front();
          if (akind != e.kind || cyc != e.cyc ||
              (akind == K_RD && bus_if.rd_data != e.data)) begin
            n_bad++;
            $display("FAIL response: got kind %0d data %02h cycle %0d, required kind %0d data %02h cycle %0d",
                     akind, bus_if.rd_data, cyc, e.kind, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_of(input int k);
    logic [247:0] f;
    f = regs_flat;
    return f[k*8 +: 8];
  endfunction

  task automatic access(input logic [30:0] rs, input logic rnw, input logic [7:0] d,
                        input int kind, input logic [7:0] ed);
    exp_t e;
    @(posedge clk);
    #1;
    bus_if.rs_vector = rs;
    bus_if.r_neg_w   = rnw;
    bus_if.wr_data   = d;
    e.kind = kind;
    e.data = ed;
    e.cyc  = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus_if.rs_vector = '0;
      irq = '0;
    end
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    @(posedge clk);
    #1;
    irq = v;
    idle(1);
  endtask

  initial begin
    logic [247:0] exp_flat;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    status = 8'h00;
    irq = 8'h00;
    bus_if.rs_vector = '0;
    bus_if.r_neg_w   = 1'b0;
    bus_if.wr_data   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    exp_flat = '0;
    exp_flat[7:0] = 8'h01;
    n_cmp++;
    if (regs_flat !== exp_flat) begin
      n_bad++;
      $display("FAIL reset_regs: got %h, required %h", regs_flat, exp_flat);
    end
    check("reset_mode", 32'(reset_mode), 32'd1);
    check("reset_pulses", {29'd0, bus_if.rd_valid, bus_if.wr_ack, bus_if.acc_err}, 32'd0);
    check("reset_rd_data", 32'(bus_if.rd_data), 32'h00);

    // Reset-only register in reset mode, then leave reset mode and retry
    access(31'd1 << 5, 1'b0, 8'hA5, K_WR, 8'h00);
    idle(1);
    check("reg5_write", 32'(reg_of(5)), 32'hA5);
    access(31'd1 << 0, 1'b0, 8'h00, K_WR, 8'h00);
    idle(1);
    check("mode_cleared", 32'(reset_mode), 32'd0);
    access(31'd1 << 5, 1'b0, 8'h3C, K_ERR, 8'h00);
    idle(1);
    check("reg5_protected", 32'(reg_of(5)), 32'hA5);

    // Read-only target and two-hot selects
    access(31'd1 << 3, 1'b0, 8'hFF, K_ERR, 8'h00);
    access(31'h3, 1'b0, 8'h55, K_ERR, 8'h00);
    access(31'h3, 1'b1, 8'h00, K_ERR, 8'h00);
    idle(1);
    check("reg3_unchanged", 32'(reg_of(3)), 32'h00);
    check("mode_unchanged", 32'(reg_of(0)), 32'h00);

    access(31'd1 << 9, 1'b0, 8'h9C, K_WR, 8'h00);
    idle(1);
    check("reg9_normal_write", 32'(reg_of(9)), 32'h9C);

    // Mode change governs protection from the very next cycle
    access(31'd1 << 0, 1'b0, 8'h01, K_WR, 8'h00);
    access(31'd1 << 4, 1'b0, 8'h44, K_WR, 8'h00);
    access(31'd1 << 0, 1'b0, 8'h00, K_WR, 8'h00);
    access(31'd1 << 8, 1'b0, 8'h88, K_ERR, 8'h00);
    idle(1);
    check("reg4_after_mode_set", 32'(reg_of(4)), 32'h44);
    check("reg8_after_mode_clr", 32'(reg_of(8)), 32'h00);

    // Interrupt register: read-to-clear, and set winning over clear
    pulse_irq(8'h05);
    check("ir_set", 32'(reg_of(3)), 32'h05);
    access(31'd1 << 3, 1'b1, 8'h00, K_RD, 8'h05);
    idle(1);
    check("ir_cleared", 32'(reg_of(3)), 32'h00);
    pulse_irq(8'h05);
    access(31'd1 << 3, 1'b1, 8'h00, K_RD, 8'h05);
    irq = 8'h02;
    idle(1);
    check("ir_set_beats_clear", 32'(reg_of(3)), 32'h02);
    access(31'd1 << 3, 1'b1, 8'h00, K_RD, 8'h02);
    idle(1);
    check("ir_cleared_again", 32'(reg_of(3)), 32'h00);

    // Status passthrough and read data hold across a write
    status = 8'h5A;
    access(31'd1 << 2, 1'b1, 8'h00, K_RD, 8'h5A);
    idle(1);
    status = 8'h00;
    access(31'd1 << 9, 1'b0, 8'h12, K_WR, 8'h00);
    idle(1);
    check("rd_data_held", 32'(bus_if.rd_data), 32'h5A);

    // Back-to-back write then read of the same register
    access(31'd1 << 10, 1'b0, 8'h11, K_WR, 8'h00);
    access(31'd1 << 10, 1'b1, 8'h00, K_RD, 8'h11);
    idle(1);

    access(31'd1 << 0, 1'b0, 8'h80, K_WR, 8'h00);
    idle(1);
`ifdef CAN_REG_ACC_ERR_EN
    check("mode_bit7_dropped", 32'(reg_of(0)), 32'h00);
`else
    check("mode_bit7_stored", 32'(reg_of(0)), 32'h80);
`endif
    check("mode_bit7_not_rst", 32'(reset_mode), 32'd0);

    // Async reset in the middle of an access aborts it silently
    @(posedge clk);
    #1;
    bus_if.rs_vector = 31'd1 << 11;
    bus_if.r_neg_w   = 1'b0;
    bus_if.wr_data   = 8'h77;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    bus_if.rs_vector = '0;
    rst = 1'b0;
    @(negedge clk);
    check("abort_reg11", 32'(reg_of(11)), 32'h00);
    check("abort_mode", 32'(reset_mode), 32'd1);
    check("abort_rd_data", 32'(bus_if.rd_data), 32'h00);
    check("abort_reg5", 32'(reg_of(5)), 32'h00);

`ifdef CAN_REG_ACC_ERR_EN
    check("err_cnt_reset", 32'(err_cnt), 32'h00);
    check("err_sticky_reset", 32'(err_sticky), 32'd0);
    for (int i = 0; i < 300; i++) begin
      access(31'd1 << 2, 1'b0, 8'h01, K_ERR, 8'h00);
    end
    idle(1);
    check("err_cnt_sat", 32'(err_cnt), 32'hFF);
    check("err_sticky_set", 32'(err_sticky), 32'd1);
    access(31'd1 << 0, 1'b0, 8'h80, K_WR, 8'h00);
    idle(1);
    check("err_sticky_clr", 32'(err_sticky), 32'd0);
    check("err_cnt_kept", 32'(err_cnt), 32'hFF);
    check("mode_after_clr", 32'(reg_of(0)), 32'h00);
`endif

    idle(3);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
